// File: rtl/regfile_wb_arbiter.sv
// Purpose: round-robin share of the register-file write port between execute (A) and load/store (B), plus a pending-write scoreboard.
// Latency: a handshake in cycle N drives rf_wen/rf_waddr/rf_wdata in cycle N+1; pend_busy is combinational from registered state.
// Backpressure: grant is combinational from the valids and last winner only; the register file never stalls. Optional WB_ARB_STATS_EN adds conflict_cnt.
module regfile_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_ready,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] pend_raddr,
  output logic                  pend_busy,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0]           conflict_cnt
`endif
);

  localparam int NREGS = 1 << ADDR_WIDTH;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

  grant_e                  last_grant_q, last_grant_d;
  logic                    xfer;
  logic [ADDR_WIDTH-1:0]   gnt_addr;
  logic [DATA_WIDTH-1:0]   gnt_data;

  logic                    rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0]   rf_wdata_q, rf_wdata_d;

  logic [NREGS-1:0]        pend_q, pend_d;

  // Pick the winner: a lone requester always wins, a conflict goes to whoever did not win last.
  always_comb begin
    a_ready      = 1'b0;
    b_ready      = 1'b0;
    gnt_addr     = '0;
    gnt_data     = '0;
    last_grant_d = last_grant_q;
    if (a_valid && (!b_valid || last_grant_q == GRANT_B)) begin
      a_ready      = 1'b1;
      gnt_addr     = a_addr;
      gnt_data     = a_data;
      last_grant_d = GRANT_A;
    end else if (b_valid) begin
      b_ready      = 1'b1;
      gnt_addr     = b_addr;
      gnt_data     = b_data;
      last_grant_d = GRANT_B;
    end
  end

  assign xfer = a_ready | b_ready;

  // Register-file drive: writes to x0 complete the handshake but never pulse wen; addr/data hold otherwise.
  always_comb begin
    rf_wen_d   = xfer && (gnt_addr != '0);
    rf_waddr_d = rf_wen_d ? gnt_addr : rf_waddr_q;
    rf_wdata_d = rf_wen_d ? gnt_data : rf_wdata_q;
  end

  // Scoreboard next state: issue beats a same-register retire (newer producer still pending); flush beats everything.
  always_comb begin
    pend_d = pend_q;
    if (flush) begin
      pend_d = '0;
    end else begin
      if (xfer) pend_d[gnt_addr] = 1'b0;
      if (issue_valid && (issue_rd != '0)) pend_d[issue_rd] = 1'b1;
    end
  end

  // State registers; reset leaves last winner as B so A takes the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GRANT_B;
      rf_wen_q     <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      pend_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_wen_q     <= rf_wen_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      pend_q       <= pend_d;
    end
  end

  assign rf_wen    = rf_wen_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign pend_busy = (pend_raddr != '0) && pend_q[pend_raddr];

`ifdef WB_ARB_STATS_EN
  logic [31:0] conflict_q;

  // Count cycles with both requesters contending, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_q <= '0;
    end else if (a_valid && b_valid && (conflict_q != 32'hFFFF_FFFF)) begin
      conflict_q <= conflict_q + 32'd1;
    end
  end

  assign conflict_cnt = conflict_q;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: A = execute unit, B = load/store unit.
- Round-robin arbitration with a valid/ready handshake per requester.
- Registered drive of the register file's wen/waddr/wdata.
- Per-register pending-write scoreboard, so decode can detect RAW hazards against in-flight results.

Parameters:
- ADDR_WIDTH, 5, register address width; the scoreboard holds 2**ADDR_WIDTH bits.
- DATA_WIDTH, 32, writeback data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- a_valid  in  1  requester A has a writeback.
- a_addr  in  ADDR_WIDTH  A destination register.
- a_data  in  DATA_WIDTH  A result.
- a_ready  out  1  A accepted this cycle (combinational grant).
- b_valid  in  1  requester B has a writeback.
- b_addr  in  ADDR_WIDTH  B destination register.
- b_data  in  DATA_WIDTH  B result.
- b_ready  out  1  B accepted this cycle (combinational grant).
- issue_valid  in  1  decode issued an instruction that writes issue_rd.
- issue_rd  in  ADDR_WIDTH  destination of the issued instruction.
- flush  in  1  synchronous clear of all pending bits.
- pend_raddr  in  ADDR_WIDTH  scoreboard query address.
- pend_busy  out  1  query result (combinational).
- rf_wen  out  1  register-file write enable (registered).
- rf_waddr  out  ADDR_WIDTH  register-file write address (registered).
- rf_wdata  out  DATA_WIDTH  register-file write data (registered).

Behaviour:
- Reset (async, rst_n=0):
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - All scoreboard bits 0.
  - last_grant=B, so A wins the first conflict.
  - a_ready/b_ready follow the combinational rules below; both are 0 while the corresponding valid is 0.
- Arbitration (combinational):
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the requester that is not last_grant.
  - At most one of a_ready/b_ready is high in any cycle.
  - A transfer occurs on valid&&ready.
  - Grant never depends on anything downstream; the register file always accepts.
- last_grant updates on posedge to the granted requester on any transfer. It holds when there is no transfer.
- Requester rules: a requester holding valid must keep addr/data stable until ready. Dropping valid before ready is legal; the request is discarded.
- Write latency: a transfer in cycle N drives rf_wen=1 with the granted addr/data in cycle N+1, for exactly one cycle. rf_wen=0 in every cycle with no transfer. rf_waddr/rf_wdata hold their last values when rf_wen=0.
- x0 suppression:
  - A transfer with addr==0 completes the handshake (ready=1) but produces rf_wen=0 in N+1.
  - issue_rd==0 never sets a scoreboard bit.
  - pend_busy for pend_raddr==0 is always 0.
- Scoreboard (posedge, after reset release):
  - issue_valid && issue_rd!=0 sets bit[issue_rd].
  - A transfer clears bit[granted addr].
  - Set and clear to the same register in the same cycle: set wins (a newer producer is pending).
  - flush=1 clears all bits and overrides issue and clear in that cycle. flush does not affect the handshake or rf_* outputs; a transfer in the flush cycle still writes.
- pend_busy = bit[pend_raddr] from current register state. The same-cycle issue or clear is not visible until the next cycle.
- Reset mid-operation: a transfer in flight in cycle N with reset asserted in N+1 is dropped. rf_wen is forced 0 immediately (asynchronously).

Optional Feature:
- Macro: WB_ARB_STATS_EN.
- Defined:
  - Adds output conflict_cnt (32 bits).
  - Resets to 0 and increments by 1 on every cycle where a_valid&&b_valid.
  - Saturates at 32'hFFFFFFFF; unaffected by flush.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Basic write: a_valid=1, a_addr=5, a_data=32'h1234 for one cycle -> a_ready=1 that cycle; next cycle rf_wen=1, rf_waddr=5, rf_wdata=32'h1234; following cycle rf_wen=0.
- Round-robin: a_valid=b_valid=1 held for 4 cycles with distinct addrs, first conflict after reset -> grants A,B,A,B; rf_waddr sequence matches one cycle later; with WB_ARB_STATS_EN, conflict_cnt=4.
- x0 suppression:
  - b_valid=1, b_addr=0, b_data=32'hDEAD -> b_ready=1; rf_wen stays 0 next cycle.
  - issue_valid=1, issue_rd=0 -> pend_busy(0)=0.
- Scoreboard set/clear: issue_rd=7 at cycle 0 -> pend_busy(7)=1 from cycle 1; A writes addr 7 at cycle 3 -> pend_busy(7)=0 from cycle 4.
- Same-cycle collision: bit 9 pending; in one cycle issue_rd=9 and A transfers addr 9 -> pend_busy(9) remains 1 next cycle; a flush the following cycle -> pend_busy(9)=0.
- Async reset: transfer in cycle N, rst_n low mid-cycle N+1 -> rf_wen drops to 0 immediately; all pend_busy=0; first conflict after release grants A.
